// File: rtl/delta_decoder_accum.sv
// Delta decoder: rebuilds absolute values from {carry, difference} pairs by running
// accumulation, one registered output stage with valid/ready on both sides, fixed-length frames.
module delta_decoder_accum #(
    parameter int SIZE      = 5,
    parameter int FRAME_LEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_diff,
    input  logic            in_carry,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    output logic            err
);
    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state;
    logic [SIZE-1:0]         acc;
    logic [CNT_W-1:0]        cnt;
    logic                    vld_p0;
    logic                    last_p0;
    logic signed [SIZE:0]    delta_p0;
    logic signed [SIZE+1:0]  acc_ext_p0;
    logic signed [SIZE+1:0]  delta_ext_p0;
    logic signed [SIZE+1:0]  sum_p0;

    // acc is 0..2^SIZE-1 and delta is -2^SIZE..2^SIZE-1, so the sum spans -2^SIZE..2^(SIZE+1)-2:
    // negative sets the top bit, above the value range sets bit SIZE.
    function automatic logic out_of_range(input logic signed [SIZE+1:0] s);
        return s[SIZE+1] | s[SIZE];
    endfunction

    function automatic logic [SIZE-1:0] wrap(input logic signed [SIZE+1:0] s);
        return s[SIZE-1:0];
    endfunction

    assign in_ready  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign vld_p0    = in_valid && in_ready;
    assign last_p0   = (cnt == CNT_LAST);

    // Stage p0: decode the delta and add it to the running value
    assign delta_p0     = $signed({~in_carry, in_diff});
    assign acc_ext_p0   = $signed({2'b00, acc});
    assign delta_ext_p0 = {delta_p0[SIZE], delta_p0};
    assign sum_p0       = acc_ext_p0 + delta_ext_p0;

    // Stage p1: output register, accumulator and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_last <= 1'b0;
            err      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else if (vld_p0) begin
            state    <= FULL;
            out_data <= wrap(sum_p0);
            out_last <= last_p0;
            if (out_of_range(sum_p0))
                err <= 1'b1;
            if (last_p0) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= wrap(sum_p0);
                cnt <= cnt + 1'b1;
            end
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_delta_decoder_accum.sv
// Bench for delta_decoder_accum (SIZE=5, FRAME_LEN=4): vector table plus hand sequences,
// expected outputs queued on accept and compared when the output handshake happens.
module tb_delta_decoder_accum;
    localparam int SIZE = 5;
    localparam int FLEN = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_diff;
    logic            in_carry;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic            out_last;
    logic            err;

    typedef struct {
        logic            c;
        logic [SIZE-1:0] d;
        logic [SIZE-1:0] ed;
        logic            el;
        logic            ee;
    } vec_t;

    typedef struct {
        logic [SIZE-1:0] data;
        logic            last;
        logic            err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[18];
    int   tests = 0;
    int   fails = 0;

    delta_decoder_accum #(.SIZE(SIZE), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output-side scoreboard: compare on every completed output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got data %0d with empty queue", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_last", 32'(out_last), 32'(e.last));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    // Present one sample and hold it until accepted; optionally queue its expected result
    task automatic send(input logic c, input logic [SIZE-1:0] d, input logic [SIZE-1:0] ed,
                        input logic el, input logic ee, input bit push);
        int  n;
        bit  done;
        exp_t e;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_carry = c;
        in_diff  = d;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    e.data = ed; e.last = el; e.err = ee;
                    sb.push_back(e);
                end
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_midcycle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
    endtask

    initial begin
        // frame A: plain stream
        tbl[0]  = '{1'b1, 5'd3,  5'd3,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd7,  5'd10, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd29, 5'd7,  1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd2,  5'd9,  1'b1, 1'b0};
        // frame B: wrap into next frame decoded from 0
        tbl[4]  = '{1'b1, 5'd1,  5'd1,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd1,  5'd2,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 5'd1,  5'd3,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd1,  5'd4,  1'b1, 1'b0};
        // frame C: -1, zero delta, exact upper bound
        tbl[8]  = '{1'b1, 5'd6,  5'd6,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd31, 5'd5,  1'b0, 1'b0};
        tbl[10] = '{1'b1, 5'd0,  5'd5,  1'b0, 1'b0};
        tbl[11] = '{1'b1, 5'd26, 5'd31, 1'b1, 1'b0};
        // frame D: overflow sets sticky err, then underflow
        tbl[12] = '{1'b1, 5'd3,  5'd3,  1'b0, 1'b0};
        tbl[13] = '{1'b1, 5'd31, 5'd2,  1'b0, 1'b1};
        tbl[14] = '{1'b0, 5'd31, 5'd1,  1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'd29, 5'd30, 1'b1, 1'b1};
        // frame E: -1 from 0, then most negative delta
        tbl[16] = '{1'b0, 5'd31, 5'd31, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 5'd0,  5'd31, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_carry = 1'b0; in_diff = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Back-to-back table stream with out_ready high
        for (int i = 0; i < 18; i++)
            send(tbl[i].c, tbl[i].d, tbl[i].ed, tbl[i].el, tbl[i].ee, 1'b1);
        idle(3);

        // Async reset while a sample is held and err is set: frame position is at sample 2
        out_ready = 1'b0;
        send(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_err", 32'(err), 32'd1);
        pulse_reset_midcycle();

        // Backpressure: first output held, second sample waits
        send(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in_carry = 1'b1; in_diff = 5'd7;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'd3);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b1, 5'd7, 5'd10, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Reset mid-frame after 2 samples: next frame restarts at 0
        pulse_reset_midcycle();
        send(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1);
        send(1'b1, 5'd1, 5'd6, 1'b0, 1'b0, 1'b1);
        send(1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1);
        send(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("end_queue_empty", 32'(sb.size()), 32'd0);
        check("end_out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
